// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and build defaults for the PWM sequencer.
//               Holds the sequencer state encoding and the default width,
//               period and duty used by pwm_seq_ctrl and pwm_cnt_cmp.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int unsigned c_DEFAULT_WIDTH  = 8;
    localparam int unsigned c_DEFAULT_PERIOD = 255;
    localparam int unsigned c_DEFAULT_DUTY   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_cnt_cmp.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cnt_cmp
// Description : Period counter with wrap detect and registered duty compare.
//   ck      in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   run     in   sequencer is active this cycle (counter advances)
//   clr     in   next cycle is idle: force count and output low
//   period  in   active period value (wrap when cnt == period)
//   duty    in   duty value in effect for the next cycle
//   cnt     out  current count
//   wrap    out  this edge is a period boundary (only while run)
//   pwm_out out  registered output, equal to (cnt < duty in effect)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cnt_cmp
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             pwm_out
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_pwm;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign wrap = run && (r_cnt == period);

    // When not running and not cleared we are leaving IDLE: the first active
    // cycle starts at zero, so the next count is zero in both cases.
    always_comb begin
        w_cnt_nxt = '0;
        if (!clr && run) begin
            w_cnt_nxt = wrap ? '0 : (r_cnt + WIDTH'(1));
        end
    end

    // The compare uses the next count and next duty so the flopped output
    // lines up with the count it belongs to.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_pwm <= !clr && (w_cnt_nxt < duty);
        end
    end

    assign cnt     = r_cnt;
    assign pwm_out = r_pwm;

endmodule : pwm_cnt_cmp
`default_nettype wire

// File: rtl/pwm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_seq_ctrl
// Description : Single-channel PWM sequencer. Config arrives on a valid/ready
//               handshake into pending (shadow) registers and is moved to the
//               active registers in IDLE or on a period boundary.
//   ck         in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   run request (level)
//   cfg_valid  in   config offer
//   cfg_ready  out  config accept (registered, = !pend_vld)
//   cfg_period in   requested period (length = value + 1 cycles)
//   cfg_duty   in   requested high time in cycles
//   pwm_out    out  registered PWM output
//   busy       out  high in RUN or DRAIN
//   period_irq out  one-cycle pulse after each boundary (PWM_PERIOD_IRQ_EN)
//   cnt        out  current count
// Build option: define PWM_PERIOD_IRQ_EN to add the period_irq output.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH          = c_DEFAULT_WIDTH,
    parameter int unsigned DEFAULT_PERIOD = c_DEFAULT_PERIOD,
    parameter int unsigned DEFAULT_DUTY   = c_DEFAULT_DUTY
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             busy,
`ifdef PWM_PERIOD_IRQ_EN
    output logic             period_irq,
`endif
    output logic [WIDTH-1:0] cnt
);

    pwm_state_t       r_state;
    pwm_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_act_period;
    logic [WIDTH-1:0] r_act_duty;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_duty;
    logic             r_pend_vld;
    logic             r_cfg_ready;
    logic             r_busy;

    logic             w_xfer;
    logic             w_active;
    logic             w_wrap;
    logic             w_apply;
    logic             w_clr;
    logic             w_pend_vld_nxt;
    logic [WIDTH-1:0] w_duty_nxt;

    assign w_xfer   = cfg_valid && r_cfg_ready;
    assign w_active = (r_state != IDLE);
    // Pending values move in while idle or at a boundary. A transfer on the
    // same edge cannot coincide: pend_vld=1 means cfg_ready=0.
    assign w_apply  = r_pend_vld && ((r_state == IDLE) || w_wrap);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN:     if (!en) w_state_nxt = DRAIN;
            DRAIN: begin
                if (en)          w_state_nxt = RUN;
                else if (w_wrap) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pend_vld_nxt = r_pend_vld;
        if (w_xfer)       w_pend_vld_nxt = 1'b1;
        else if (w_apply) w_pend_vld_nxt = 1'b0;
    end

    assign w_clr      = (w_state_nxt == IDLE);
    assign w_duty_nxt = w_apply ? r_pend_duty : r_act_duty;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_act_period  <= WIDTH'(DEFAULT_PERIOD);
            r_act_duty    <= WIDTH'(DEFAULT_DUTY);
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_pend_vld    <= 1'b0;
            r_cfg_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_cfg_ready <= !w_pend_vld_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            if (w_xfer) begin
                r_pend_period <= cfg_period;
                r_pend_duty   <= cfg_duty;
            end
            if (w_apply) begin
                r_act_period <= r_pend_period;
                r_act_duty   <= r_pend_duty;
            end
        end
    end

    pwm_cnt_cmp #(
        .WIDTH (WIDTH)
    ) u_cnt_cmp (
        .ck      (ck),
        .rst     (rst),
        .run     (w_active),
        .clr     (w_clr),
        .period  (r_act_period),
        .duty    (w_duty_nxt),
        .cnt     (cnt),
        .wrap    (w_wrap),
        .pwm_out (pwm_out)
    );

`ifdef PWM_PERIOD_IRQ_EN
    // Pulse lands in the cnt==0 cycle after every boundary, including the
    // final DRAIN boundary; IDLE->RUN entry is not a boundary.
    logic r_period_irq;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) r_period_irq <= 1'b0;
        else     r_period_irq <= w_wrap;
    end

    assign period_irq = r_period_irq;
`endif

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;

endmodule : pwm_seq_ctrl
`default_nettype wire

// File: tb/tb_pwm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_seq_ctrl
// Description : Directed self-checking bench for pwm_seq_ctrl with default
//               parameters (WIDTH=8, period 255, duty 0). Expected values are
//               written out per step from the intended waveform.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_seq_ctrl;

    logic       ck;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       pwm_out;
    logic       busy;
    logic [7:0] cnt;
`ifdef PWM_PERIOD_IRQ_EN
    logic       period_irq;
`endif

    int    n_err;
    int    n_chk;
    string phase;

    pwm_seq_ctrl u_dut (
        .ck         (ck),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .busy       (busy),
`ifdef PWM_PERIOD_IRQ_EN
        .period_irq (period_irq),
`endif
        .cnt        (cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d, want %0d", phase, tag, got, exp);
        end
    endtask

    // One clock edge, then compare every output against the given values.
    task automatic step_chk(input int c, input logic p, input logic rdy,
                            input logic b, input logic irq);
        @(posedge ck);
        #1;
        check("cnt",  32'(cnt),       32'(c));
        check("pwm",  32'(pwm_out),   32'(p));
        check("rdy",  32'(cfg_ready), 32'(rdy));
        check("busy", 32'(busy),      32'(b));
`ifdef PWM_PERIOD_IRQ_EN
        check("irq",  32'(period_irq), 32'(irq));
`endif
    endtask

    task automatic apply_reset();
        en        = 1'b0;
        cfg_valid = 1'b0;
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
    endtask

    // From IDLE: transfer (p,d), let IDLE apply it, then enable. Returns in
    // the first RUN cycle (cnt=0).
    task automatic setup(input logic [7:0] p, input logic [7:0] d);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        #1;
        check("rdy_pre", 32'(cfg_ready), 32'd1);
        step_chk(0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        step_chk(0, 1'b0, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        step_chk(0, d > 8'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        n_err      = 0;
        n_chk      = 0;
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;

        // Reset state
        phase = "reset";
        #3;
        check("cnt",  32'(cnt),       32'd0);
        check("pwm",  32'(pwm_out),   32'd0);
        check("rdy",  32'(cfg_ready), 32'd1);
        check("busy", 32'(busy),      32'd0);
`ifdef PWM_PERIOD_IRQ_EN
        check("irq",  32'(period_irq), 32'd0);
`endif

        // 1: defaults, run 512 cycles with duty 0
        phase = "defaults";
        @(negedge ck);
        rst = 1'b0;
        en  = 1'b1;
        #1;
        check("busy0", 32'(busy), 32'd0);
        for (int k = 0; k < 512; k++)
            step_chk(k % 256, 1'b0, 1'b1, 1'b1, (k > 0) && ((k % 256) == 0));

        // 2: configure 9/3 in IDLE, 3 high / 7 low
        phase = "cfg_idle";
        apply_reset();
        setup(8'd9, 8'd3);
        for (int i = 1; i < 30; i++)
            step_chk(i % 10, (i % 10) < 3, 1'b1, 1'b1, (i % 10) == 0);

        // 3: mid-period transfer of duty 7, second offer held off
        phase = "midxfer";
        for (int c = 0; c <= 4; c++)
            step_chk(c, c < 3, 1'b1, 1'b1, c == 0);
        cfg_valid  = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd7;
        step_chk(5, 1'b0, 1'b0, 1'b1, 1'b0);
        cfg_duty = 8'd2;
        for (int c = 6; c <= 9; c++)
            step_chk(c, 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk(0, 1'b1, 1'b1, 1'b1, 1'b1);
        step_chk(1, 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        for (int c = 2; c <= 9; c++)
            step_chk(c, c < 7, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c <= 9; c++)
            step_chk(c, c < 2, 1'b1, 1'b1, c == 0);

        // 4: transfer exactly on the boundary edge
        phase = "bndxfer";
        apply_reset();
        setup(8'd9, 8'd3);
        for (int c = 1; c <= 9; c++)
            step_chk(c, c < 3, 1'b1, 1'b1, 1'b0);
        cfg_valid  = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd5;
        step_chk(0, 1'b1, 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        for (int c = 1; c <= 9; c++)
            step_chk(c, c < 3, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c <= 9; c++)
            step_chk(c, c < 5, 1'b1, 1'b1, c == 0);

        // 5: drain to idle, then re-enable mid-drain and at a drain boundary
        phase = "drain";
        apply_reset();
        setup(8'd9, 8'd3);
        step_chk(1, 1'b1, 1'b1, 1'b1, 1'b0);
        step_chk(2, 1'b1, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        for (int c = 3; c <= 9; c++)
            step_chk(c, 1'b0, 1'b1, 1'b1, 1'b0);
        step_chk(0, 1'b0, 1'b1, 1'b0, 1'b1);
        step_chk(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step_chk(0, 1'b0, 1'b1, 1'b0, 1'b0);
        phase = "reen";
        en = 1'b1;
        step_chk(0, 1'b1, 1'b1, 1'b1, 1'b0);
        step_chk(1, 1'b1, 1'b1, 1'b1, 1'b0);
        step_chk(2, 1'b1, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        for (int c = 3; c <= 6; c++)
            step_chk(c, 1'b0, 1'b1, 1'b1, 1'b0);
        en = 1'b1;
        for (int c = 7; c <= 9; c++)
            step_chk(c, 1'b0, 1'b1, 1'b1, 1'b0);
        step_chk(0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++)
            step_chk(c, c < 3, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        for (int c = 6; c <= 9; c++)
            step_chk(c, 1'b0, 1'b1, 1'b1, 1'b0);
        en = 1'b1;
        step_chk(0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++)
            step_chk(c, c < 3, 1'b1, 1'b1, 1'b0);

        // 6: asynchronous reset mid-period with a pending config
        phase = "asyncrst";
        apply_reset();
        setup(8'd9, 8'd7);
        for (int c = 1; c <= 3; c++)
            step_chk(c, 1'b1, 1'b1, 1'b1, 1'b0);
        cfg_valid  = 1'b1;
        cfg_period = 8'd9;
        cfg_duty   = 8'd4;
        step_chk(4, 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step_chk(5, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("cnt",  32'(cnt),       32'd0);
        check("pwm",  32'(pwm_out),   32'd0);
        check("rdy",  32'(cfg_ready), 32'd1);
        check("busy", 32'(busy),      32'd0);
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
        phase = "postrst";
        for (int k = 0; k < 300; k++)
            step_chk(k % 256, 1'b0, 1'b1, 1'b1, (k > 0) && ((k % 256) == 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pwm_seq_ctrl
`default_nettype wire

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
Single-channel PWM sequencer. It runs the period counter and duty comparator that drive the registered PWM output flop. Configuration arrives over a valid/ready handshake and is shadowed, so new period/duty values apply only on a period boundary. It sits between the register/config interface and the PWM output pin.

Parameters:
WIDTH, 8, width of the counter, period and duty values
DEFAULT_PERIOD, 255, active period value loaded on reset (period length = value + 1 cycles)
DEFAULT_DUTY, 0, active duty value loaded on reset

Ports:
ck  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
en  in  1  run request (level)
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept
cfg_period  in  WIDTH  requested period value
cfg_duty  in  WIDTH  requested high-time in cycles
pwm_out  out  1  registered PWM output
busy  out  1  high in RUN or DRAIN
cnt  out  WIDTH  current count, for debug and observation

Behaviour:
- Interface: one clock, ck; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, pwm_out=0, busy=0, cfg_ready=1, act_period=DEFAULT_PERIOD, act_duty=DEFAULT_DUTY, pend_vld=0.
- Handshake:
  - Transfer occurs when cfg_valid and cfg_ready are both high on a rising edge; the transfer captures cfg_period and cfg_duty into the pending registers and sets pend_vld.
  - cfg_ready is registered and equals !pend_vld; it drops the cycle after a transfer.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold the offer.
- States:
  - IDLE: cnt=0, pwm_out=0. If pend_vld, the pending values move to active on the next edge and pend_vld clears. en=1 moves to RUN on the next edge, with cnt=0 in the first RUN cycle.
  - RUN: on each edge, cnt increments. When cnt==act_period it wraps to 0 instead; that wrap is the period boundary. At the boundary, if pend_vld, active takes the pending values and pend_vld clears. en=0 moves to DRAIN on the next edge, with counting continuing.
  - DRAIN: counting continues. At the boundary, go to IDLE (cnt=0, pwm_out=0). If en=1 at the boundary, return to RUN with no gap. If en rises mid-period, move to RUN on the next edge and keep cnt.
- Output rule: in RUN and DRAIN, pwm_out is registered and aligned with cnt, i.e. pwm_out==(cnt<act_duty) for the act_duty in effect that cycle.
- Edge cases:
  - act_duty=0 gives a constant low output.
  - act_duty>act_period gives a constant high output.
  - act_period=0 gives a 1-cycle period.
- Simultaneous events:
  - A transfer on a boundary edge is not applied at that boundary; it applies at the following boundary.
  - A transfer on the IDLE→RUN edge applies at the first boundary.
- Width: compares are unsigned at WIDTH bits; there is no saturation logic.
- Reset mid-period forces all reset values immediately; any pending config is discarded.

Optional Feature:
- Macro: PWM_PERIOD_IRQ_EN.
- When defined, an extra output period_irq (1 bit, reset 0) is added. It is a registered single-cycle pulse, high in the cycle where cnt==0 following each boundary in RUN or DRAIN, including the final DRAIN boundary. It is not asserted on IDLE→RUN entry.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pwm_pkg holds:
  - the state enum (IDLE, RUN, DRAIN)
  - localparam defaults for DEFAULT_PERIOD and DEFAULT_DUTY
  - the WIDTH default
- One sub-module, pwm_cnt_cmp, holds the counter with wrap detect and the registered duty compare. It takes ck, rst, run, clr, period and duty, and produces cnt, wrap and pwm_out.
- FSM, handshake and shadow registers stay in the top.

Test Plan:
1. Reset with defaults, en=1, no config → pwm_out stays 0 for 512 cycles; cnt wraps 255→0 every 256 cycles; busy=1 from the second cycle.
2. In IDLE, transfer period=9, duty=3, then en=1 → repeating pattern of 3 high / 7 low starting at cnt=0; cfg_ready low for exactly 1 cycle after the transfer.
3. In RUN with period=9, duty=3, transfer duty=7 at cnt=4 → the current period stays at 3 high; the next period is 7 high. A second offer while cfg_ready=0 is held off until the boundary.
4. Transfer exactly on the boundary edge (cnt 9→0) with duty=5 → the following period is still 3 high; the new duty appears one period later.
5. en drops at cnt=2 → the period completes (DRAIN), then IDLE with pwm_out=0, busy=0. Repeat, raising en at cnt=6 in DRAIN → stays in RUN with no gap in the count.
6. Assert rst at cnt=5 with pwm_out=1 and a pending config → pwm_out=0, cnt=0, cfg_ready=1 asynchronously; defaults active after release. With PWM_PERIOD_IRQ_EN defined, period_irq pulses once per boundary and never during IDLE.
